// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit and its operand muxes.
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int ITERS_DEFAULT = 32;

  // Multiply/divide opcode encodings as presented on the op port.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Forwarding selects from the forwarding unit; 2'b11 falls back to ID/EX.
  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  // Bit 0 clear means the signed flavour (MULT / DIV).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 set means a divide (DIV / DIVU).
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage bundle between the pipeline and the multiply/divide unit.
// Handshake: start is a request qualified by !abort; the unit accepts it only
// in IDLE. While busy, stall is raised for any start or hilo_read so the
// pipeline holds the instruction until the unit returns to IDLE.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  import muldiv_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [1:0]      forward_A;
  logic [1:0]      forward_B;
  logic [XLEN-1:0] id_ex_rs_data;
  logic [XLEN-1:0] id_ex_rt_data;
  logic [XLEN-1:0] ex_mem_result;
  logic [XLEN-1:0] mem_wb_data;
  logic            hilo_read;
  logic            abort;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  state_t          dbg_state;

  modport master (
    output start, op, forward_A, forward_B, id_ex_rs_data, id_ex_rt_data,
           ex_mem_result, mem_wb_data, hilo_read, abort,
    input  stall, busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, forward_A, forward_B, id_ex_rs_data, id_ex_rt_data,
           ex_mem_result, mem_wb_data, hilo_read, abort,
    output stall, busy, done, hi, lo, dbg_state
  );

endinterface

// File: rtl/ex_operand_mux.sv
// 3:1 forwarding mux for one EX operand; an unused select reads ID/EX.
module ex_operand_mux
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] id_ex_data,
  input  logic [W-1:0] ex_mem_data,
  input  logic [W-1:0] mem_wb_data,
  output logic [W-1:0] y
);

  // Pick the freshest copy of the operand named by the forwarding unit.
  always_comb begin
    y = id_ex_data;
    case (sel)
      FWD_EXMEM: y = ex_mem_data;
      FWD_MEMWB: y = mem_wb_data;
      default:   y = id_ex_data;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit holding HI/LO. Multiply is radix-2
// shift-add, divide is restoring; both run on unsigned magnitudes with a
// sign fixup in the final cycle.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  ex_muldiv_if.slave   bus
);

  localparam int CW = $clog2(ITERS);

  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   m_reg;
  logic [XLEN-1:0]   a_raw;
  logic              is_div;
  logic              sign_a;
  logic              sign_b;
  logic              b_zero;
  logic [XLEN-1:0]   hi_reg;
  logic [XLEN-1:0]   lo_reg;
  logic              done_reg;

  logic              accept;
  logic              last_iter;
  logic              in_signed;
  logic              in_sign_a;
  logic              in_sign_b;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   hi_res;
  logic [XLEN-1:0]   lo_res;

  ex_operand_mux #(.W(XLEN)) u_mux_a (
    .sel         (bus.forward_A),
    .id_ex_data  (bus.id_ex_rs_data),
    .ex_mem_data (bus.ex_mem_result),
    .mem_wb_data (bus.mem_wb_data),
    .y           (opa)
  );

  ex_operand_mux #(.W(XLEN)) u_mux_b (
    .sel         (bus.forward_B),
    .id_ex_data  (bus.id_ex_rt_data),
    .ex_mem_data (bus.ex_mem_result),
    .mem_wb_data (bus.mem_wb_data),
    .y           (opb)
  );

  // Issue-side decode: acceptance, operand signs and magnitudes.
  always_comb begin
    accept    = (state == ST_IDLE) && bus.start && !bus.abort;
    last_iter = (cnt == CW'(ITERS - 1));
    in_signed = op_is_signed(bus.op);
    in_sign_a = in_signed && opa[XLEN-1];
    in_sign_b = in_signed && opb[XLEN-1];
    a_mag     = in_sign_a ? (~opa + 1'b1) : opa;
    b_mag     = in_sign_b ? (~opb + 1'b1) : opb;
  end

  // One iteration of the datapath. acc holds {partial product, multiplier}
  // for multiply and {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_reg} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, m_reg};
    acc_step  = {mul_sum, acc[XLEN-1:1]};
    if (is_div) begin
      if (div_diff[XLEN]) acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end
  end

  // Sign fixup and divide-by-zero override applied in FIN.
  always_comb begin
    mul_res = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo     = acc[XLEN-1:0];
    rem     = acc[2*XLEN-1:XLEN];
    hi_res  = mul_res[2*XLEN-1:XLEN];
    lo_res  = mul_res[XLEN-1:0];
    if (is_div) begin
      if (b_zero) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = sign_a ? (~rem + 1'b1) : rem;
        lo_res = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort wins over both iteration and completion.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.abort)      state_next = ST_IDLE;
        else if (last_iter) state_next = ST_FIN;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and HI/LO writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      m_reg    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state == ST_FIN) && !bus.abort;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt    <= '0;
            is_div <= op_is_div(bus.op);
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            a_raw  <= opa;
            b_zero <= (opb == '0);
            if (op_is_div(bus.op)) begin
              m_reg <= b_mag;
              acc   <= {{XLEN{1'b0}}, a_mag};
            end else begin
              m_reg <= a_mag;
              acc   <= {{XLEN{1'b0}}, b_mag};
            end
          end
        end
        ST_RUN: begin
          if (!bus.abort) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIN: begin
          if (!bus.abort) begin
            hi_reg <= hi_res;
            lo_reg <= lo_res;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs toward hazard control and the register file path.
  always_comb begin
    bus.busy      = (state != ST_IDLE);
    bus.stall     = bus.busy && (bus.hilo_read || bus.start);
    bus.done      = done_reg;
    bus.hi        = hi_reg;
    bus.lo        = lo_reg;
    bus.dbg_state = state;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: cycle-accurate latency, signed fixups,
// forwarding, stall behaviour, abort and mid-operation reset.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exm;
    logic [31:0] mwb;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks; inputs change just after the falling edge, outputs are
  // sampled there too, half a period away from the active edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.start         = 1'b0;
    bus.op            = OP_MULT;
    bus.forward_A     = FWD_IDEX;
    bus.forward_B     = FWD_IDEX;
    bus.id_ex_rs_data = '0;
    bus.id_ex_rt_data = '0;
    bus.ex_mem_result = '0;
    bus.mem_wb_data   = '0;
    bus.hilo_read     = 1'b0;
    bus.abort         = 1'b0;
  endtask

  // Present an op in cycle 0; returns in cycle 1 with start dropped.
  task automatic issue(input logic [1:0] op, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] exm, input logic [31:0] mwb);
    bus.op            = op;
    bus.forward_A     = fa;
    bus.forward_B     = fb;
    bus.id_ex_rs_data = rs;
    bus.id_ex_rt_data = rt;
    bus.ex_mem_result = exm;
    bus.mem_wb_data   = mwb;
    bus.start         = 1'b1;
    step();
    bus.start         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.start = 1'b1;
    step_n(3);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b state=%0d, expected 0 0 0",
               bus.busy, bus.done, bus.dbg_state);
    end
    tests_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_hilo: hi=%h lo=%h, expected 0 0", bus.hi, bus.lo);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b stall=%b, expected 0 0", bus.busy, bus.stall);
    end
  endtask

  task automatic test_multu_latency();
    int bad_busy;
    int bad_done;
    bad_busy = 0;
    bad_done = 0;
    issue(OP_MULTU, FWD_IDEX, FWD_IDEX, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.done !== 1'b0) bad_done++;
      step();
    end
    tests_run++;
    if (bad_busy != 0 || bad_done != 0) begin
      tests_failed++;
      $display("FAIL multu_busy_window: busy low %0d times, done early %0d times, expected 0 0",
               bad_busy, bad_done);
    end
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL multu_done_c34: done=%b busy=%b, expected 1 0", bus.done, bus.busy);
    end
    tests_run++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL multu_result: hi=%h lo=%h, expected fffffffe 00000001", bus.hi, bus.lo);
    end
    step();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL multu_done_pulse: done=%b in cycle 35, expected 0", bus.done);
    end
  endtask

  task automatic test_mult();
    vec_t v[3];
    v[0] = '{OP_MULT, FWD_EXMEM, FWD_MEMWB, 32'h1234_5678, 32'h9ABC_DEF0,
             32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    v[1] = '{OP_MULT, FWD_IDEX, FWD_IDEX, 32'hFFFF_FFFC, 32'hFFFF_FFFB,
             32'h0, 32'h0, 32'h0000_0000, 32'h0000_0014};
    v[2] = '{OP_MULT, FWD_MEMWB, FWD_EXMEM, 32'h1, 32'h1,
             32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].op, v[i].fa, v[i].fb, v[i].rs, v[i].rt, v[i].exm, v[i].mwb);
      step_n(33);
      tests_run++;
      if (bus.done !== 1'b1 || bus.hi !== v[i].hi || bus.lo !== v[i].lo) begin
        tests_failed++;
        $display("FAIL mult_vec%0d: done=%b hi=%h lo=%h, expected 1 %h %h",
                 i, bus.done, bus.hi, bus.lo, v[i].hi, v[i].lo);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[6];
    v[0] = '{OP_DIV,  FWD_IDEX, FWD_IDEX, 32'hFFFF_FFF9, 32'h0000_0002,
             32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[1] = '{OP_DIVU, FWD_IDEX, FWD_IDEX, 32'd100, 32'd0,
             32'h0, 32'h0, 32'd100, 32'hFFFF_FFFF};
    v[2] = '{OP_DIV,  FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000};
    v[3] = '{OP_DIV,  FWD_IDEX, FWD_IDEX, 32'hFFFF_FFFB, 32'h0,
             32'h0, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    v[4] = '{OP_DIVU, 2'b11, 2'b11, 32'd17, 32'd5,
             32'd1000, 32'd2000, 32'd2, 32'd3};
    v[5] = '{OP_DIV,  FWD_IDEX, FWD_IDEX, 32'd7, 32'hFFFF_FFFE,
             32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFD};
    for (int i = 0; i < 6; i++) begin
      issue(v[i].op, v[i].fa, v[i].fb, v[i].rs, v[i].rt, v[i].exm, v[i].mwb);
      step_n(33);
      tests_run++;
      if (bus.done !== 1'b1 || bus.hi !== v[i].hi || bus.lo !== v[i].lo) begin
        tests_failed++;
        $display("FAIL div_vec%0d: done=%b hi=%h lo=%h, expected 1 %h %h",
                 i, bus.done, bus.hi, bus.lo, v[i].hi, v[i].lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad_stall;
    bad_stall = 0;
    issue(OP_MULTU, FWD_IDEX, FWD_IDEX, 32'd6, 32'd7, 32'h0, 32'h0);
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) bus.hilo_read = 1'b1;
      if (c == 10) begin
        bus.op            = OP_MULTU;
        bus.id_ex_rs_data = 32'd3;
        bus.id_ex_rt_data = 32'd4;
        bus.start         = 1'b1;
      end
      #1;
      if (bus.stall !== (c >= 5)) bad_stall++;
      step();
    end
    tests_run++;
    if (bad_stall != 0) begin
      tests_failed++;
      $display("FAIL stall_window: %0d cycles wrong in 1..33, expected 0", bad_stall);
    end
    tests_run++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      tests_failed++;
      $display("FAIL stall_release_c34: stall=%b done=%b hi=%h lo=%h, expected 0 1 0 2a",
               bus.stall, bus.done, bus.hi, bus.lo);
    end
    step();
    bus.start     = 1'b0;
    bus.hilo_read = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_start_accept: busy=%b done=%b in cycle 35, expected 1 0",
               bus.busy, bus.done);
    end
    step_n(33);
    tests_run++;
    if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      tests_failed++;
      $display("FAIL held_start_result: done=%b hi=%h lo=%h, expected 1 0 c",
               bus.done, bus.hi, bus.lo);
    end
    step();
  endtask

  task automatic test_abort();
    int done_seen;
    // Seed HI/LO with 0x11/0x22: 0x451 / 0x20 = 0x22 rem 0x11.
    issue(OP_DIVU, FWD_IDEX, FWD_IDEX, 32'h451, 32'h20, 32'h0, 32'h0);
    step_n(33);
    tests_run++;
    if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      tests_failed++;
      $display("FAIL abort_seed: hi=%h lo=%h, expected 11 22", bus.hi, bus.lo);
    end
    step();

    // Abort during RUN.
    issue(OP_DIVU, FWD_IDEX, FWD_IDEX, 32'd9, 32'd3, 32'h0, 32'h0);
    step_n(14);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE || bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      tests_failed++;
      $display("FAIL abort_run_c16: busy=%b state=%0d hi=%h lo=%h, expected 0 0 11 22",
               bus.busy, bus.dbg_state, bus.hi, bus.lo);
    end
    done_seen = 0;
    for (int c = 0; c < 24; c++) begin
      if (bus.done !== 1'b0) done_seen++;
      step();
    end
    tests_run++;
    if (done_seen != 0 || bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      tests_failed++;
      $display("FAIL abort_run_quiet: done seen %0d hi=%h lo=%h, expected 0 11 22",
               done_seen, bus.hi, bus.lo);
    end

    // Abort coinciding with FIN.
    issue(OP_MULTU, FWD_IDEX, FWD_IDEX, 32'd2, 32'd3, 32'h0, 32'h0);
    step_n(32);
    tests_run++;
    if (bus.dbg_state !== ST_FIN) begin
      tests_failed++;
      $display("FAIL fin_cycle33: state=%0d, expected %0d", bus.dbg_state, ST_FIN);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      tests_failed++;
      $display("FAIL abort_fin: done=%b busy=%b hi=%h lo=%h, expected 0 0 11 22",
               bus.done, bus.busy, bus.hi, bus.lo);
    end

    // Abort alongside start in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle_start: busy=%b, expected 0", bus.busy);
    end

    // Reset in the middle of an op.
    issue(OP_DIVU, FWD_IDEX, FWD_IDEX, 32'd9, 32'd3, 32'h0, 32'h0);
    step_n(14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_midop: busy=%b state=%0d hi=%h lo=%h, expected 0 0 0 0",
               bus.busy, bus.dbg_state, bus.hi, bus.lo);
    end
    done_seen = 0;
    for (int c = 0; c < 24; c++) begin
      if (bus.done !== 1'b0) done_seen++;
      step();
    end
    tests_run++;
    if (done_seen != 0 || bus.lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_midop_quiet: done seen %0d lo=%h, expected 0 0", done_seen, bus.lo);
    end
  endtask

  // Test sequence and final report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive_idle();
    test_reset();
    test_multu_latency();
    test_mult();
    test_div();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes the forwarding unit's forward_A/forward_B selects and the candidate operand values.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the HI/LO architectural registers.
- Drives a stall request to hazard control while a result is pending and a dependent op (MFHI/MFLO or a new mul/div) sits in EX.

Parameters:
- XLEN, 32, operand/result width; the only supported value is 32.
- ITERS, 32, shift-add / restoring-divide iterations; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  mul/div instruction valid in EX this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- forward_A  in  2  operand A select: 00 ID/EX, 10 EX/MEM, 01 MEM/WB, 11 treated as 00
- forward_B  in  2  operand B select, same encoding
- id_ex_rs_data  in  32  rs value from ID/EX
- id_ex_rt_data  in  32  rt value from ID/EX
- ex_mem_result  in  32  EX/MEM ALU result
- mem_wb_data  in  32  MEM/WB writeback data
- hilo_read  in  1  MFHI/MFLO in EX this cycle
- abort  in  1  synchronous kill of in-flight op (exception flush)
- stall  out  1  hold PC, IF/ID and ID/EX
- busy  out  1  op in flight
- done  out  1  one-cycle pulse when HI/LO update
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst=1 at posedge):
  - State returns to IDLE.
  - hi=0, lo=0, done=0, busy=0.
  - Iteration counter and datapath registers are cleared.
  - Reset overrides start and abort, and applies in any state, including mid-operation.
- Operand mux (combinational):
  - A = forward_A==10 ? ex_mem_result : forward_A==01 ? mem_wb_data : id_ex_rs_data.
  - B is the same with id_ex_rt_data as the default source.
- States: IDLE, RUN, FIN.
  - IDLE: if start && !abort, latch the mux outputs, op and the operand signs; take absolute values for MULT/DIV; counter=0; go to RUN.
  - RUN: one iteration per cycle (mul: 64-bit shift-add; div: restoring, 1 quotient bit per cycle). Counter increments. After ITERS iterations go to FIN.
  - FIN: apply sign fixup, write hi/lo, set done register, go to IDLE.
- Latency: start accepted at cycle 0; RUN occupies cycles 1..32; FIN is cycle 33; new hi/lo and done=1 are visible in cycle 34.
- busy=1 in RUN and FIN, 0 in IDLE.
- stall = busy && (hilo_read || start). A start while busy is not accepted and is held by the stall. It is accepted in the first IDLE cycle, which is the done cycle.
- Multiply results:
  - MULTU: {hi,lo} = A*B unsigned.
  - MULT: magnitude product; negated (64-bit two's complement) if signA^signB.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if signA^signB; remainder takes the sign of A.
  - -2^31 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (B==0): normal latency; hi=A (unmodified dividend), lo=0xFFFFFFFF; no trap.
- abort:
  - In RUN/FIN: return to IDLE next cycle; hi/lo unchanged; no done.
  - In IDLE with start: start is ignored.
  - abort beats FIN completion when both occur in the same cycle.
- hi/lo change only in FIN→IDLE and at reset. done is never high for two consecutive cycles.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - forward select constants (FWD_IDEX=00, FWD_EXMEM=10, FWD_MEMWB=01)
  - state encoding
  - ITERS default
- One sub-module: ex_operand_mux, a 3:1 forwarding mux instantiated twice (A, B). Reusable by the ALU operand path.

Test Plan:
- MULTU A=0xFFFFFFFF (fwd 00), B=0xFFFFFFFF -> cycle 34: hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy=1 cycles 1..33.
- MULT with forward_A=10, ex_mem_result=0xFFFFFFFD (-3), forward_B=01, mem_wb_data=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; id_ex_* values ignored.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/0 -> hi=100, lo=0xFFFFFFFF at cycle 34.
- Start MULTU 6*7, then hilo_read=1 at cycle 5 -> stall=1 cycles 5..33, 0 at cycle 34; hi=0, lo=42 on the same cycle. Second start at cycle 10 is stalled and accepted at cycle 34.
- abort at cycle 15 of DIVU 9/3 (prior hi/lo = 0x11/0x22) -> IDLE at cycle 16, busy=0, no done, hi/lo remain 0x11/0x22. Repeat with rst at cycle 15 -> hi=lo=0, IDLE.
